// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit (RV-style M extension ops).
// Multiplication is radix-2 shift-add, division is radix-2 restoring.
// Both run on operand magnitudes with one bit per BUSY cycle.
// Divide-by-zero and signed overflow skip BUSY and complete in one edge.
//
// Ports:
//   clock      sole clock, rising edge
//   reset      synchronous active-high reset
//   flush      synchronous cancel of any operation in progress
//   in_valid   request valid          in_ready   block can accept a request
//   op[2:0]    MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, op[3] word mode
//   src1       multiplicand / dividend
//   src2       multiplier / divisor
//   out_valid  result valid           out_ready  consumer accepts result
//   result     operation result
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// BUSY  | iterating, one product/quotient bit per cycle
// DONE  | result held until out_ready

module mdu_iter #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] LO_MASK = XLEN'(64'h0000_0000_FFFF_FFFF);
    localparam logic [XLEN-1:0] MIN_W   = ~(LO_MASK >> 1);
    localparam logic [XLEN-1:0] MIN_X   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nx;

    // Word-mode finalisation: sign-extend the low 32 bits to XLEN.
    function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] v, input logic w);
        if (!w)
            return v;
        return v[31] ? (v | ~LO_MASK) : (v & LO_MASK);
    endfunction

    // Request decode, evaluated on the accept edge only.
    logic            word, is_div, is_rem, sgn_a, sgn_b;
    logic [2:0]      fop;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, fast_val;
    logic            neg_a, neg_b, div_zero, div_ovf, fast, accept;

    always_comb begin
        word   = (XLEN == 64) && op[3];
        fop    = (word && (op[2:0] inside {3'd1, 3'd2, 3'd3})) ? 3'd0 : op[2:0];
        is_div = fop[2];
        is_rem = fop[2] & fop[1];
        sgn_a  = fop inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
        sgn_b  = fop inside {3'd0, 3'd1, 3'd4, 3'd6};
        a_ext  = src1;
        b_ext  = src2;
        if (word) begin
            a_ext = sgn_a ? fin(src1, 1'b1) : (src1 & LO_MASK);
            b_ext = sgn_b ? fin(src2, 1'b1) : (src2 & LO_MASK);
        end
        neg_a    = sgn_a & a_ext[XLEN-1];
        neg_b    = sgn_b & b_ext[XLEN-1];
        mag_a    = neg_a ? -a_ext : a_ext;
        mag_b    = neg_b ? -b_ext : b_ext;
        div_zero = is_div & (b_ext == '0);
        div_ovf  = is_div & sgn_a & (a_ext == (word ? MIN_W : MIN_X)) & (&b_ext);
        fast     = div_zero | div_ovf;
        if (is_rem)
            fast_val = div_zero ? a_ext : '0;
        else
            fast_val = div_zero ? '1 : a_ext;
    end

    // Iteration state. For MUL: acc = partial product, aux = shifted
    // multiplicand, mq = remaining multiplier bits. For DIV: acc = {rem, quot},
    // aux[XLEN-1:0] = divisor.
    logic [2*XLEN-1:0] acc, aux;
    logic [XLEN-1:0]   mq;
    logic [CW-1:0]     count;
    logic [2:0]        fop_q;
    logic              word_q, neg_p_q, neg_a_q, last;

    logic [2*XLEN-1:0] mul_nx, div_nx, acc_nx, aux_nx, prod_s;
    logic [XLEN:0]     trial;
    logic [XLEN-1:0]   diff, quo_s, rem_s, final_val;
    logic              q_bit;

    always_comb begin
        mul_nx = acc + (mq[0] ? aux : '0);
        trial  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        q_bit  = trial >= {1'b0, aux[XLEN-1:0]};
        // When q_bit is set the true difference is below the divisor, so the
        // dropped top bit of the subtraction is always zero.
        diff   = trial[XLEN-1:0] - aux[XLEN-1:0];
        div_nx = {(q_bit ? diff : trial[XLEN-1:0]), acc[XLEN-2:0], q_bit};
        acc_nx = fop_q[2] ? div_nx : mul_nx;
        aux_nx = fop_q[2] ? aux : (aux << 1);
        // Sign correction is folded into the final iteration so DONE needs no
        // extra cycle.
        prod_s = neg_p_q ? -mul_nx : mul_nx;
        quo_s  = neg_p_q ? -div_nx[XLEN-1:0] : div_nx[XLEN-1:0];
        rem_s  = neg_a_q ? -div_nx[2*XLEN-1:XLEN] : div_nx[2*XLEN-1:XLEN];
        case (fop_q)
            3'd0:             final_val = fin(prod_s[XLEN-1:0], word_q);
            3'd1, 3'd2, 3'd3: final_val = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       final_val = fin(quo_s, word_q);
            default:          final_val = fin(rem_s, word_q);
        endcase
        last = (count == (word_q ? CW'(31) : CW'(XLEN - 1)));
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nx = fast ? DONE : BUSY;
            end
            BUSY: begin
                if (last)
                    state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush)
            state_nx = IDLE;
    end

    assign accept = in_ready & in_valid & ~flush;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            result  <= '0;
            acc     <= '0;
            aux     <= '0;
            mq      <= '0;
            fop_q   <= '0;
            word_q  <= 1'b0;
            neg_p_q <= 1'b0;
            neg_a_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                count   <= '0;
                fop_q   <= fop;
                word_q  <= word;
                neg_p_q <= neg_a ^ neg_b;
                neg_a_q <= neg_a;
                mq      <= mag_b;
                if (is_div) begin
                    // Left-align the dividend so the next bit is always the MSB.
                    acc <= {{XLEN{1'b0}}, (word ? (mag_a << (XLEN / 2)) : mag_a)};
                    aux <= {{XLEN{1'b0}}, mag_b};
                end else begin
                    acc <= '0;
                    aux <= {{XLEN{1'b0}}, mag_a};
                end
                if (fast)
                    result <= fin(fast_val, word);
            end else if (state == BUSY && !flush) begin
                count <= count + CW'(1);
                acc   <= acc_nx;
                aux   <= aux_nx;
                mq    <= mq >> 1;
                if (last)
                    result <= final_val;
            end
        end
    end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning the datapath width; legal values are 32 and 64.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous cancel of any operation in progress.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port op  input  4  operation code:
- op[2:0]: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op[3]: word mode.
REQ-008 SHALL have port src1  input  XLEN  multiplicand or dividend.
REQ-009 SHALL have port src2  input  XLEN  multiplier or divisor.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port result  output  XLEN  operation result.

Function
REQ-013 SHALL implement states IDLE, BUSY and DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 SHALL accept a request on an edge where in_valid & in_ready & ~flush, latching op, src1 and src2.
REQ-016 SHALL ignore src1, src2 and op at all times other than the accept edge.
REQ-017 SHALL use N = XLEN iterations, or N = 32 when op[3] = 1 and XLEN = 64.
REQ-018 SHALL ignore op[3] when XLEN = 32.
REQ-019 SHALL, in word mode, take the low 32 bits of each operand, sign-extended for signed operands and zero-extended for unsigned operands.
REQ-020 SHALL, in word mode, return result[31:0] sign-extended to XLEN.
REQ-021 SHALL treat word-mode op[2:0] in 1..3 as word MUL.
REQ-022 SHALL perform multiplication as radix-2 shift-add on operand magnitudes, one bit per BUSY cycle, over a 2N-bit product.
REQ-023 SHALL select signedness as: MUL and MULH signed x signed; MULHSU signed src1 x unsigned src2; MULHU unsigned x unsigned.
REQ-024 SHALL return the low N product bits for MUL and the high N bits for MULH, MULHSU and MULHU.
REQ-025 SHALL perform division as radix-2 restoring division on magnitudes, one quotient bit per BUSY cycle.
REQ-026 SHALL give the quotient the sign of (src1 XOR src2) and the remainder the sign of src1, for signed operations.
REQ-027 SHALL move IDLE -> BUSY on accept, with iteration count reset to 0.
REQ-028 SHALL move BUSY -> DONE on the edge completing iteration N.
REQ-029 SHALL produce out_valid first in the cycle N clock edges after the accept edge.
REQ-030 SHALL apply sign correction as the result register is written on entry to DONE, with no extra cycle.
REQ-031 SHALL take a fast path IDLE -> DONE on the accept edge (out_valid one edge after accept) for divide by zero.
- Quotient = all ones.
- Remainder = dividend, after word extension.
REQ-032 SHALL take the same fast path for signed overflow (dividend = most-negative, divisor = -1, in the effective width).
- Quotient = dividend.
- Remainder = 0.
REQ-033 SHALL hold result and out_valid stable while out_valid & ~out_ready.
REQ-034 SHALL move DONE -> IDLE on the edge where out_valid & out_ready.
REQ-035 SHALL raise in_ready in the cycle following the DONE -> IDLE edge; no same-cycle accept with output handshake.
REQ-036 SHALL, on flush high, move from any state to IDLE on that edge, discarding the operation, with no out_valid in the following cycle.
REQ-037 SHALL give flush priority over in_valid: no accept on a flush edge.
REQ-038 SHALL give flush priority over out_ready: a result in DONE is dropped.

Reset
REQ-039 SHALL, on reset high at a clock edge, enter IDLE with in_ready = 1, out_valid = 0, result = 0 and iteration count = 0.
REQ-040 SHALL give reset priority over flush and all handshakes, including mid-BUSY and in DONE.

Verification
REQ-041 SHALL cover XLEN=64 MUL src1=7, src2=0xFFFF_FFFF_FFFF_FFFD -> result 0xFFFF_FFFF_FFFF_FFEB, out_valid 64 edges after accept.
REQ-042 SHALL cover MULHU src1=src2=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE; MULH of the same operands -> 0.
REQ-043 SHALL cover divide by zero with src1=5, src2=0:
- DIV -> 0xFFFF_FFFF_FFFF_FFFF, one edge after accept.
- REMU -> 5.
REQ-044 SHALL cover signed overflow with src1=0x8000_0000_0000_0000, src2=all ones:
- DIV -> 0x8000_0000_0000_0000.
- REM -> 0.
- Fast-path latency of one edge.
REQ-045 SHALL cover word mode, op[3]=1, src1=0x1234_5678_FFFF_FFF9, src2=2:
- DIV -> 0xFFFF_FFFF_FFFF_FFFD.
- REM -> 0xFFFF_FFFF_FFFF_FFFF.
- out_valid 32 edges after accept.
REQ-046 SHALL cover backpressure and flush:
- out_ready low 10 cycles in DONE -> result and out_valid unchanged.
- flush at BUSY iteration 20 -> in_ready=1 next cycle, out_valid never asserted.
- A new request accepted immediately after completes correctly.
